// File: rtl/arb_pkg.sv
// Shared types and default sizes for the arbiter requester-side controller.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      DONE
   } arb_port_state_t;

   localparam int unsigned NUM_PORTS_DEF = 5;
   localparam int unsigned LEN_W_DEF     = 8;

endpackage

// File: rtl/arb_req_port.sv
// One client port: accepts a burst job, requests the arbiter until every beat
// has been granted, then pulses done for one cycle.
module arb_req_port
   import arb_pkg::*;
#(
   parameter int unsigned LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_job_valid,
   input  logic [LEN_W-1:0] i_job_len,
   input  logic             i_gnt,
   output logic             o_job_ready,
   output logic             o_req,
   output logic             o_beat,
   output logic             o_done
);

   arb_port_state_t  r_state;
   arb_port_state_t  w_state_nxt;
   logic [LEN_W-1:0] r_rem;
   logic [LEN_W-1:0] w_rem_nxt;

   // State and remaining-beat registers; reset discards any burst in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_rem   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rem   <= w_rem_nxt;
      end
   end

   // Next state, beat counting and outputs. req comes straight from the state
   // register, so it is glitch-free and appears the cycle after accept.
   always_comb begin
      w_state_nxt = r_state;
      w_rem_nxt   = r_rem;
      o_job_ready = 1'b0;
      o_req       = 1'b0;
      o_beat      = 1'b0;
      o_done      = 1'b0;
      unique case (r_state)
         IDLE: begin
            o_job_ready = 1'b1;
            if (i_job_valid) begin
               w_rem_nxt   = i_job_len;
               // A zero-length job completes without ever touching the arbiter.
               w_state_nxt = (i_job_len == '0) ? DONE : ACTIVE;
            end
         end
         ACTIVE: begin
            o_req  = 1'b1;
            o_beat = i_gnt;
            // Ungranted cycles (preempted) simply hold the count.
            if (i_gnt) begin
               w_rem_nxt = r_rem - LEN_W'(1);
               if (r_rem == LEN_W'(1)) begin
                  w_state_nxt = DONE;
               end
            end
         end
         DONE: begin
            // Request drops for this cycle so lower-priority ports can win.
            o_done      = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: rtl/arb_req_ctrl.sv
// Requester-side controller for a fixed-priority arbiter: one burst FSM per
// client port plus a sticky check on the grant vector returned by the arbiter.
module arb_req_ctrl
   import arb_pkg::*;
#(
   parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
   parameter int unsigned LEN_W     = LEN_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_PORTS-1:0]       job_valid_i,
   input  logic [NUM_PORTS*LEN_W-1:0] job_len_i,
   output logic [NUM_PORTS-1:0]       job_ready_o,
   output logic [NUM_PORTS-1:0]       req_o,
   input  logic [NUM_PORTS-1:0]       gnt_i,
   output logic [NUM_PORTS-1:0]       beat_o,
   output logic [NUM_PORTS-1:0]       done_o,
   output logic                       err_o
);

   logic [NUM_PORTS-1:0] w_req;
   logic                 w_multi_gnt;
   logic                 w_stray_gnt;
   logic                 r_err;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      arb_req_port #(
         .LEN_W (LEN_W)
      ) u_port (
         .clk         (clk),
         .rst         (rst),
         .i_job_valid (job_valid_i[p]),
         .i_job_len   (job_len_i[p*LEN_W +: LEN_W]),
         .i_gnt       (gnt_i[p]),
         .o_job_ready (job_ready_o[p]),
         .o_req       (w_req[p]),
         .o_beat      (beat_o[p]),
         .o_done      (done_o[p])
      );
   end

   assign req_o = w_req;

   // More than one bit set: clearing the lowest set bit leaves something behind.
   assign w_multi_gnt = |(gnt_i & (gnt_i - NUM_PORTS'(1)));
   assign w_stray_gnt = |(gnt_i & ~w_req);

   // Sticky protocol-error flag, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_multi_gnt || w_stray_gnt) begin
         r_err <= 1'b1;
      end
   end

   assign err_o = r_err;

endmodule

// File: tb/tb_arb_req_ctrl.sv
// Self-checking bench for arb_req_ctrl: directed scenarios plus a randomized
// run, all compared every cycle against a job-level model of each port.
module tb_arb_req_ctrl;

   localparam int NP = 5;
   localparam int LW = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NP-1:0]     job_valid_i;
   logic [NP*LW-1:0]  job_len_i;
   logic [NP-1:0]     job_ready_o;
   logic [NP-1:0]     req_o;
   logic [NP-1:0]     gnt_i;
   logic [NP-1:0]     beat_o;
   logic [NP-1:0]     done_o;
   logic              err_o;

   arb_req_ctrl #(
      .NUM_PORTS (NP),
      .LEN_W     (LW)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .job_valid_i (job_valid_i),
      .job_len_i   (job_len_i),
      .job_ready_o (job_ready_o),
      .req_o       (req_o),
      .gnt_i       (gnt_i),
      .beat_o      (beat_o),
      .done_o      (done_o),
      .err_o       (err_o)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   // Job-level model: is a job owed beats, how many remain, is completion due.
   bit m_busy [NP];
   int m_left [NP];
   bit m_done [NP];
   bit m_err;

   int last_done [NP];
   int beats     [NP];
   int reqs      [NP];

   int            stall_pct = 0;
   bit            inj_on    = 1'b0;
   logic [NP-1:0] inj_val   = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
   endtask

   task automatic model_reset();
      for (int p = 0; p < NP; p++) begin
         m_busy[p] = 1'b0;
         m_left[p] = 0;
         m_done[p] = 1'b0;
      end
      m_err = 1'b0;
   endtask

   task automatic clear_stats();
      for (int p = 0; p < NP; p++) begin
         last_done[p] = -1;
         beats[p]     = 0;
         reqs[p]      = 0;
      end
   endtask

   task automatic set_job(input int p, input int len);
      job_valid_i[p]            = 1'b1;
      job_len_i[p*LW +: LW]     = LW'(len);
   endtask

   // One clock: drive grant, compare at the falling edge, advance the model.
   task automatic cycle();
      logic [NP-1:0] e_ready, e_req, e_beat, e_done, g;
      int            lenp;
      if (inj_on) gnt_i = inj_val;
      else if ($urandom_range(99) < stall_pct) gnt_i = '0;
      else gnt_i = req_o & (~req_o + 1'b1);
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
         e_ready[p] = !m_busy[p] && !m_done[p];
         e_req[p]   = m_busy[p];
         e_beat[p]  = m_busy[p] && gnt_i[p];
         e_done[p]  = m_done[p];
      end
      check("job_ready_o", 32'(job_ready_o), 32'(e_ready));
      check("req_o", 32'(req_o), 32'(e_req));
      check("beat_o", 32'(beat_o), 32'(e_beat));
      check("done_o", 32'(done_o), 32'(e_done));
      check("err_o", 32'(err_o), 32'(m_err));
      for (int p = 0; p < NP; p++) begin
         if (done_o[p]) last_done[p] = cyc;
         beats[p] += int'(beat_o[p]);
         reqs[p]  += int'(req_o[p]);
      end
      g = gnt_i;
      if ($countones(g) > 1 || (g & e_req) != g) m_err = 1'b1;
      for (int p = 0; p < NP; p++) begin
         if (m_done[p]) begin
            m_done[p] = 1'b0;
         end else if (m_busy[p]) begin
            if (g[p]) begin
               m_left[p]--;
               if (m_left[p] == 0) begin
                  m_busy[p] = 1'b0;
                  m_done[p] = 1'b1;
               end
            end
         end else if (job_valid_i[p]) begin
            lenp = int'(job_len_i[p*LW +: LW]);
            if (lenp == 0) m_done[p] = 1'b1;
            else begin
               m_busy[p] = 1'b1;
               m_left[p] = lenp;
            end
         end
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      job_valid_i = '0;
      gnt_i       = '0;
      inj_on      = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int c;
      rst         = 1'b1;
      job_valid_i = '0;
      job_len_i   = '0;
      gnt_i       = '0;
      model_reset();
      clear_stats();
      repeat (2) @(posedge clk);
      #1;
      check("reset job_ready_o", 32'(job_ready_o), 32'h1f);
      check("reset req_o", 32'(req_o), 32'h0);
      check("reset done_o", 32'(done_o), 32'h0);
      check("reset err_o", 32'(err_o), 32'h0);
      rst = 1'b0;

      // Single uncontended burst.
      clear_stats();
      c = cyc;
      set_job(2, 3);
      cycle();
      job_valid_i = '0;
      repeat (8) cycle();
      check("t1 done latency", last_done[2] - c, 4);
      check("t1 beats", beats[2], 3);
      check("t1 req cycles", reqs[2], 3);

      // Preemption of port 3 by port 0.
      clear_stats();
      c = cyc;
      set_job(3, 4);
      cycle();
      job_valid_i = '0;
      cycle();
      set_job(0, 2);
      cycle();
      job_valid_i = '0;
      repeat (8) cycle();
      check("t2 port0 done", last_done[0] - c, 5);
      check("t2 port3 done", last_done[3] - c, 7);
      check("t2 port3 beats", beats[3], 4);
      check("t2 port3 req cycles", reqs[3], 6);

      // Zero-length job.
      clear_stats();
      c = cyc;
      set_job(1, 0);
      cycle();
      job_valid_i = '0;
      repeat (3) cycle();
      check("t3 done", last_done[1] - c, 1);
      check("t3 no req", reqs[1], 0);

      // Back-to-back jobs with valid held high.
      clear_stats();
      c = cyc;
      set_job(0, 1);
      repeat (4) cycle();
      job_valid_i = '0;
      repeat (4) cycle();
      check("t4 second done", last_done[0] - c, 5);
      check("t4 beats", beats[0], 2);
      check("t4 req cycles", reqs[0], 2);

      // Multi-hot grant sets the sticky error.
      inj_on  = 1'b1;
      inj_val = 5'b00011;
      cycle();
      inj_on  = 1'b0;
      inj_val = '0;
      check("t5 err after multi", 32'(err_o), 32'h1);
      repeat (3) cycle();
      check("t5 err sticky", 32'(err_o), 32'h1);

      // Grant to an idle port: error, but no beat.
      do_reset();
      clear_stats();
      inj_on  = 1'b1;
      inj_val = 5'b10000;
      cycle();
      inj_on  = 1'b0;
      inj_val = '0;
      cycle();
      check("t5 stray beat", beats[4], 0);
      check("t5 err after stray", 32'(err_o), 32'h1);

      // Reset in the middle of a burst.
      do_reset();
      clear_stats();
      set_job(4, 5);
      cycle();
      job_valid_i = '0;
      cycle();
      gnt_i = req_o & (~req_o + 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("t6 req_o", 32'(req_o), 32'h0);
      check("t6 job_ready_o", 32'(job_ready_o), 32'h1f);
      check("t6 done_o", 32'(done_o), 32'h0);
      check("t6 err_o", 32'(err_o), 32'h0);
      model_reset();
      gnt_i = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_stats();
      repeat (8) cycle();
      check("t6 no done", last_done[4], -1);

      // Randomized traffic with arbiter stalls and occasional resets.
      stall_pct = 30;
      for (int blk = 0; blk < 4; blk++) begin
         do_reset();
         for (int i = 0; i < 700; i++) begin
            for (int p = 0; p < NP; p++) begin
               if ($urandom_range(3) == 0) begin
                  if ($urandom_range(19) == 0) set_job(p, int'($urandom_range(255)));
                  else set_job(p, int'($urandom_range(6)));
               end else begin
                  job_valid_i[p] = 1'b0;
               end
            end
            cycle();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
